sixteen_bit_accumulator: RTL and testbench
==========================================

Name: sixteen_bit_accumulator

Overview:
Sequential accumulator stage that sits directly upstream of, and wraps, the team's 16-bit adder/subtractor datapath. It accepts operand/opcode transactions over a valid/ready handshake and holds a 16-bit running accumulator. It drives the adder/subtractor with the accumulator and operand, and registers the result plus status flags. Results are presented downstream over a second valid/ready handshake.

Parameters:
OP_COUNT_W, 8, width of the completed-operation counter op_count.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream transaction valid.
in_ready  output  1  block can accept a transaction.
in_op  input  2  opcode: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
in_operand  input  16  operand B.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
acc_out  output  16  accumulator value.
flag_carry  output  1  adder carry-out. For SUB, 1 means no borrow.
flag_ovf  output  1  signed two's-complement overflow.
flag_zero  output  1  acc_out == 0.
flag_neg  output  1  acc_out[15].
op_count  output  OP_COUNT_W  number of results consumed downstream.

Behaviour:
- Reset (async assert, sync release), all outputs low/zero:
  - acc_out=0, all flags=0, out_valid=0, op_count=0, in_ready=0.
  - FSM in IDLE; in_ready rises in the first cycle after reset deasserts.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_op/in_operand into internal registers and go to EXEC.
  - EXEC: in_ready=0, one cycle. Adder inputs are i0=acc, i1=operand, cin=(op==SUB). At the clock edge, register the result, update flags, go to RESP.
  - RESP: out_valid=1; acc_out and flags stay stable. On out_ready, out_valid drops, op_count increments, and the FSM returns to IDLE.
- Latency: result is valid 2 cycles after the accept edge. Maximum throughput is 1 transaction per 3 cycles when out_ready is tied high.
- Opcode effects:
  - LOAD: acc=operand; carry=0, ovf=0.
  - CLEAR: acc=0; carry=0, ovf=0; operand ignored.
  - ADD: acc=acc+operand (mod 2^16).
  - SUB: acc=acc-operand (mod 2^16).
- Flag rules for ADD/SUB:
  - carry = adder carry-out (bit 16).
  - ovf = (acc[15]==b'[15]) & (sum[15]!=acc[15]), where b' = operand XOR {16{cin}}.
  - zero and neg are always derived from the newly registered acc.
- Boundaries:
  - 0xFFFF+1 gives 0x0000, carry=1, zero=1, ovf=0.
  - 0x8000-1 gives 0x7FFF, ovf=1, carry=1.
  - 0-1 gives 0xFFFF, carry=0, neg=1.
- in_valid while not IDLE is ignored; upstream must hold it.
- A stalled out_ready holds RESP indefinitely with no state change.
- op_count wraps from 2^OP_COUNT_W-1 to 0.
- rst mid-operation (EXEC/RESP) aborts the transaction immediately and returns all outputs to their reset values. No partial update survives.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: ADD/SUB with ovf=1 clamps acc to 0x7FFF (positive overflow, acc[15]=0) or 0x8000 (negative overflow). flag_ovf still reads 1. carry is unchanged.
- Undefined: wrap-around arithmetic exactly as in Behaviour; the clamp logic is absent.

Decomposition:
- Shared package acc_pkg:
  - opcode enum (OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_CLEAR=2'b11).
  - FSM state enum (IDLE, EXEC, RESP).
  - constants SAT_POS=16'h7FFF, SAT_NEG=16'h8000.
- Sub-module: instantiate the existing sixteen_bit_full_adder_subtractor as the combinational datapath. Its carry output feeds flag_carry. All new logic is sequential control around it; no further sub-modules.

Test Plan:
- Reset release, then LOAD 0x1234 with out_ready=1: out_valid at accept+2, acc_out=0x1234, all flags 0, op_count=1.
- LOAD 0xFFFF, then ADD 0x0001: acc_out=0x0000, carry=1, zero=1, ovf=0, neg=0.
- LOAD 0x8000, then SUB 0x0001: acc_out=0x7FFF, ovf=1, carry=1. With ACC_SATURATE_EN defined: acc_out=0x8000, ovf=1.
- LOAD 0x0000, then SUB 0x0001: acc_out=0xFFFF, carry=0, neg=1. Then CLEAR: acc_out=0, zero=1, carry=0.
- Hold out_ready=0 for 10 cycles in RESP while pulsing in_valid: in_ready stays 0, acc_out is stable, op_count is unchanged. Release out_ready: exactly one increment.
- Assert rst during EXEC of ADD 0x0005 onto 0x0003: outputs immediately return to zero. After release, out_valid stays 0 until a new transaction.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types and constants for the sixteen_bit_accumulator slice.
// Saturation constants are only referenced when ACC_SATURATE_EN is defined.
package acc_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/sixteen_bit_full_adder_subtractor.sv
// Combinational 16-bit adder/subtractor: sum = i0 + (i1 ^ {16{cin}}) + cin.
// With cin=1 this is i0 - i1, and cout=1 means no borrow.
module sixteen_bit_full_adder_subtractor (
  input  logic [15:0] i0,
  input  logic [15:0] i1,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] b_eff;

  assign b_eff       = i1 ^ {16{cin}};
  assign {cout, sum} = {1'b0, i0} + {1'b0, b_eff} + {16'b0, cin};

endmodule

// File: rtl/sixteen_bit_accumulator.sv
// Handshaked accumulator around the 16-bit adder/subtractor with registered flags.
// Optional macro ACC_SATURATE_EN clamps ADD/SUB overflow to 0x7FFF/0x8000.
//   state | meaning
//   IDLE  | ready for a transaction (once out of reset)
//   EXEC  | adder driven from acc and latched operand; result registered
//   RESP  | result presented until out_ready
module sixteen_bit_accumulator
  import acc_pkg::*;
#(
  parameter int OP_COUNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [15:0]           in_operand,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           acc_out,
  output logic                  flag_carry,
  output logic                  flag_ovf,
  output logic                  flag_zero,
  output logic                  flag_neg,
  output logic [OP_COUNT_W-1:0] op_count
);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [15:0]           operand_q;
  logic [15:0]           acc_q;
  logic                  carry_q, ovf_q, zero_q, neg_q;
  logic [OP_COUNT_W-1:0] count_q;
  logic                  live_q;

  logic        is_sub;
  logic [15:0] b_eff;
  logic [15:0] sum;
  logic        cout;
  logic        ovf_raw;
  logic [15:0] res_acc;
  logic        res_carry, res_ovf;

  assign is_sub = (op_q == OP_SUB);
  assign b_eff  = operand_q ^ {16{is_sub}};

  sixteen_bit_full_adder_subtractor u_addsub (
    .i0   (acc_q),
    .i1   (operand_q),
    .cin  (is_sub),
    .sum  (sum),
    .cout (cout)
  );

  assign ovf_raw = (acc_q[15] == b_eff[15]) && (sum[15] != acc_q[15]);

  always_comb begin
    res_acc   = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    case (op_q)
      OP_LOAD:  res_acc = operand_q;
      OP_CLEAR: res_acc = '0;
      default: begin
        res_carry = cout;
        res_ovf   = ovf_raw;
`ifdef ACC_SATURATE_EN
        if (ovf_raw) res_acc = acc_q[15] ? SAT_NEG : SAT_POS;
        else         res_acc = sum;
`else
        res_acc = sum;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // live_q keeps in_ready low while rst is held and for the release cycle
  assign in_ready  = live_q && (state_q == IDLE);
  assign out_valid = (state_q == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_LOAD;
      operand_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      live_q    <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      state_q <= state_d;
      if (state_q == IDLE && in_valid && in_ready) begin
        op_q      <= op_e'(in_op);
        operand_q <= in_operand;
      end
      if (state_q == EXEC) begin
        acc_q   <= res_acc;
        carry_q <= res_carry;
        ovf_q   <= res_ovf;
        zero_q  <= (res_acc == 16'h0000);
        neg_q   <= res_acc[15];
      end
      if (state_q == RESP && out_ready) count_q <= count_q + 1'b1;
    end
  end

  assign acc_out    = acc_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign flag_zero  = zero_q;
  assign flag_neg   = neg_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_sixteen_bit_accumulator.sv
// Directed plus random bench for sixteen_bit_accumulator against an arithmetic model.
// Follows ACC_SATURATE_EN for the expected overflow behaviour.
module tb_sixteen_bit_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] acc_out;
  logic        flag_carry, flag_ovf, flag_zero, flag_neg;
  logic [7:0]  op_count;

  int tests  = 0;
  int failed = 0;

  logic [15:0] m_acc = '0;
  logic        m_c   = 1'b0;
  logic        m_v   = 1'b0;
  logic [7:0]  m_cnt = '0;

  sixteen_bit_accumulator #(.OP_COUNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc_out    (acc_out),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected result from plain unsigned/signed integer arithmetic.
  task automatic model(input logic [1:0] op, input logic [15:0] b);
    int s, sv;
    case (op)
      2'b00: begin m_acc = b;     m_c = 1'b0; m_v = 1'b0; end
      2'b11: begin m_acc = '0;    m_c = 1'b0; m_v = 1'b0; end
      default: begin
        if (op == 2'b01) begin
          s   = int'(m_acc) + int'(b);
          sv  = int'($signed(m_acc)) + int'($signed(b));
          m_c = (s > 65535);
        end else begin
          s   = int'(m_acc) - int'(b);
          sv  = int'($signed(m_acc)) - int'($signed(b));
          m_c = (m_acc >= b);
        end
        m_v = (sv > 32767) || (sv < -32768);
        m_acc = s[15:0];
`ifdef ACC_SATURATE_EN
        if (m_v) m_acc = (sv > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
    endcase
  endtask

  task automatic check_result(input string tag);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".acc"}, {16'b0, acc_out}, {16'b0, m_acc});
    check({tag, ".flags"}, {28'b0, flag_carry, flag_ovf, flag_zero, flag_neg},
          {28'b0, m_c, m_v, (m_acc == 16'h0000), m_acc[15]});
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] b, input int stall);
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, ".ready"}, {31'b0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    in_op      = op;
    in_operand = b;
    out_ready  = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".exec_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".exec_ready"}, {31'b0, in_ready}, 32'd0);
    model(op, b);
    @(negedge clk);
    check_result(tag);
    check({tag, ".cnt_hold"}, {24'b0, op_count}, {24'b0, m_cnt});
    for (int i = 0; i < stall; i++) begin
      in_valid   = ~in_valid;
      in_op      = 2'($urandom);
      in_operand = 16'($urandom);
      @(negedge clk);
      check({tag, ".stall_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, ".stall_acc"}, {16'b0, acc_out}, {16'b0, m_acc});
      check({tag, ".stall_cnt"}, {24'b0, op_count}, {24'b0, m_cnt});
      check({tag, ".stall_valid"}, {31'b0, out_valid}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    m_cnt = m_cnt + 8'd1;
    check({tag, ".done_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".count"}, {24'b0, op_count}, {24'b0, m_cnt});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".acc"}, {16'b0, acc_out}, 32'd0);
    check({tag, ".flags"}, {28'b0, flag_carry, flag_ovf, flag_zero, flag_neg}, 32'd0);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, ".ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, ".count"}, {24'b0, op_count}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = 2'b00;
    in_operand = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("release_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("release_ready_high", {31'b0, in_ready}, 32'd1);

    run_op("load_1234", 2'b00, 16'h1234, 0);
    run_op("load_ffff", 2'b00, 16'hFFFF, 0);
    run_op("add_wrap", 2'b01, 16'h0001, 0);
    run_op("load_8000", 2'b00, 16'h8000, 0);
    run_op("sub_ovf", 2'b10, 16'h0001, 0);
    run_op("load_0", 2'b00, 16'h0000, 0);
    run_op("sub_borrow", 2'b10, 16'h0001, 0);
    run_op("clear", 2'b11, 16'hBEEF, 0);
    run_op("add_pos_ovf", 2'b01, 16'h7FFF, 0);
    run_op("add_pos_ovf2", 2'b01, 16'h7FFF, 0);
    run_op("load_stall", 2'b00, 16'h0ABC, 10);

    // abort in EXEC: ADD 5 onto 3 must leave no trace
    run_op("load_3", 2'b00, 16'h0003, 0);
    in_valid   = 1'b1;
    in_op      = 2'b01;
    in_operand = 16'h0005;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst   = 1'b0;
    m_acc = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    m_cnt = '0;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle_valid", {31'b0, out_valid}, 32'd0);
    end
    run_op("post_abort_add", 2'b01, 16'h0007, 0);

    // random traffic, long enough to wrap op_count
    for (int i = 0; i < 270; i++) begin
      run_op("rand", 2'($urandom), 16'($urandom), (i % 37 == 5) ? 3 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
